// File: rtl/cpu_pkg.sv
// Shared encodings for the datapath controller: opcode/op values, FSM state
// encoding and instruction-register field positions.
package cpu_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_e;

    localparam int IR_OPC_LSB = 13;
    localparam int IR_OP_LSB  = 11;
    localparam int IR_RN_LSB  = 8;
    localparam int IR_RD_LSB  = 5;
    localparam int IR_SH_LSB  = 3;
    localparam int IR_RM_LSB  = 0;
    localparam int IR_IMM_W   = 8;

endpackage

// File: rtl/instr_decoder.sv
// Combinational field extraction and instruction classification for the IR.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  sh,
    output logic [1:0]  op,
    output logic [15:0] sximm8,
    output logic        is_movi,
    output logic        is_movr,
    output logic        is_alu,
    output logic        is_cmp,
    output logic        is_mvn
);
    logic [2:0] opcode;

    assign opcode = ir[IR_OPC_LSB +: 3];
    assign op     = ir[IR_OP_LSB  +: 2];
    assign rn     = ir[IR_RN_LSB  +: 3];
    assign rd     = ir[IR_RD_LSB  +: 3];
    assign sh     = ir[IR_SH_LSB  +: 2];
    assign rm     = ir[IR_RM_LSB  +: 3];
    assign sximm8 = {{(16-IR_IMM_W){ir[IR_IMM_W-1]}}, ir[IR_IMM_W-1:0]};

    // is_alu covers only the two-source ops (ADD/AND) that need the A operand
    assign is_movi = (opcode == OPC_MOV) && (op == OP_MOVI);
    assign is_movr = (opcode == OPC_MOV) && (op == OP_MOVR);
    assign is_alu  = (opcode == OPC_ALU) && ((op == OP_ADD) || (op == OP_AND));
    assign is_cmp  = (opcode == OPC_ALU) && (op == OP_CMP);
    assign is_mvn  = (opcode == OPC_ALU) && (op == OP_MVN);

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction register plus Moore sequencer driving the datapath controls.
// Outputs decode from the state register, so an async reset clears them at once.
module datapath_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [15:0] sximm8,
    output logic        vsel,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop
);
    logic [15:0] ir_q, ir_d;
    state_e      state_q, state_d;

    logic [2:0] rn, rd, rm;
    logic [1:0] sh, op;
    logic       is_movi, is_movr, is_alu, is_cmp, is_mvn;

    instr_decoder u_dec (
        .ir      (ir_q),
        .rn      (rn),
        .rd      (rd),
        .rm      (rm),
        .sh      (sh),
        .op      (op),
        .sximm8  (sximm8),
        .is_movi (is_movi),
        .is_movr (is_movr),
        .is_alu  (is_alu),
        .is_cmp  (is_cmp),
        .is_mvn  (is_mvn)
    );

    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && load)
            ir_d = in;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (s) state_d = S_DECODE;
            S_DECODE: begin
                if (is_movi)                state_d = S_WR_IMM;
                else if (is_movr || is_mvn) state_d = S_GET_B;
                else if (is_alu || is_cmp)  state_d = S_GET_A;
                else                        state_d = S_WAIT;
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q    <= '0;
            state_q <= S_WAIT;
        end else begin
            ir_q    <= ir_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        w        = 1'b0;
        vsel     = 1'b0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        readnum  = rm;
        writenum = rd;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state_q)
            S_WAIT:  w = 1'b1;
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                // MOV-reg and MVN zero the A operand; MOV-reg passes B through an add
                asel  = is_movr || is_mvn;
                ALUop = is_movr ? 2'b00 : op;
                loadc = !is_cmp;
                loads = is_cmp;
            end
            S_WR_REG: begin
                writenum = rd;
                write    = 1'b1;
            end
            S_WR_IMM: begin
                vsel     = 1'b1;
                writenum = rn;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl with a small behavioural datapath as its load.
module tb_datapath_ctrl;
    logic        clk = 1'b0;
    logic        reset_n, load, s;
    logic [15:0] in;
    logic        w, vsel, write, loada, loadb, loadc, loads, asel, bsel;
    logic [15:0] sximm8;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    datapath_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s), .w(w),
        .sximm8(sximm8), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .readnum(readnum),
        .writenum(writenum), .shift(shift), .ALUop(ALUop)
    );

    // datapath load model: register file, A/B/C registers, shifter, ALU, Z flag
    logic [15:0] regs [8];
    logic [15:0] ra, rb, rc, bsh, ain, bin, alu;
    logic        zf;

    always_comb begin
        case (shift)
            2'b00:   bsh = rb;
            2'b01:   bsh = {rb[14:0], 1'b0};
            2'b10:   bsh = {1'b0, rb[15:1]};
            default: bsh = {rb[15], rb[15:1]};
        endcase
        ain = asel ? 16'h0 : ra;
        bin = bsel ? {11'h0, sximm8[4:0]} : bsh;
        case (ALUop)
            2'b00:   alu = ain + bin;
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
    end

    always @(posedge clk) begin
        if (write) regs[writenum] <= vsel ? sximm8 : rc;
        if (loada) ra <= regs[readnum];
        if (loadb) rb <= regs[readnum];
        if (loadc) rc <= alu;
        if (loads) zf <= (alu == 16'h0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard of expected register writes
    typedef struct {
        logic [2:0]  wnum;
        logic [15:0] val;
    } wr_t;
    wr_t sb[$];

    always @(negedge clk) begin
        if (reset_n && write) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {29'h0, writenum}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_num", {29'h0, writenum}, {29'h0, e.wnum});
                chk("wr_data", {16'h0, vsel ? sximm8 : rc}, {16'h0, e.val});
            end
        end
    end

    typedef struct {
        logic [15:0] instr;
        int          wcyc, nwr, nld, nen, nasel;
        logic [2:0]  rd;
        logic [15:0] val;
        logic [15:0] sx;
    } vec_t;

    // Starts at a negedge with w=1; returns at the negedge where w is next seen high.
    task automatic run(input logic [15:0] instr, output int cyc, output int nwr,
                       output int nld, output int nen, output int nasel);
        in = instr; load = 1'b1; s = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        cyc = 1; nwr = 0; nld = 0; nen = 0; nasel = 0;
        while (!w && cyc < 20) begin
            if (write) nwr++;
            if (loads) nld++;
            if (asel)  nasel++;
            if (loada | loadb | loadc | loads | write) nen++;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        vec_t vt [9];
        int cyc, nwr, nld, nen, nasel, wlow;
        logic [8:0] wpat;

        vt[0] = '{16'hD007, 3, 1, 0, 1, 0, 3'd0, 16'h0007, 16'h0007};
        vt[1] = '{16'hD102, 3, 1, 0, 1, 0, 3'd1, 16'h0002, 16'h0002};
        vt[2] = '{16'hA148, 6, 1, 0, 4, 0, 3'd2, 16'h0010, 16'h0048};
        vt[3] = '{16'hA900, 5, 0, 1, 3, 0, 3'd0, 16'h0000, 16'h0000};
        vt[4] = '{16'hD5FF, 3, 1, 0, 1, 0, 3'd5, 16'hFFFF, 16'hFFFF};
        vt[5] = '{16'hB861, 5, 1, 0, 3, 1, 3'd3, 16'hFFFD, 16'h0061};
        vt[6] = '{16'hB582, 6, 1, 0, 4, 0, 3'd4, 16'h0010, 16'hFF82};
        vt[7] = '{16'hC0D2, 5, 1, 0, 3, 1, 3'd6, 16'h0008, 16'hFFD2};
        vt[8] = '{16'h0000, 2, 0, 0, 0, 0, 3'd0, 16'h0000, 16'h0000};

        reset_n = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0;
        #12;
        chk("rst_w", {31'h0, w}, 32'h1);
        chk("rst_enables", {23'h0, write, loada, loadb, loadc, loads, asel, bsel, vsel, 1'b0}, 32'h0);
        chk("rst_sximm8", {16'h0, sximm8}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (vt[i].nwr != 0) sb.push_back('{vt[i].rd, vt[i].val});
            run(vt[i].instr, cyc, nwr, nld, nen, nasel);
            chk($sformatf("v%0d_w_cycle", i), cyc, vt[i].wcyc);
            chk($sformatf("v%0d_writes", i), nwr, vt[i].nwr);
            chk($sformatf("v%0d_loads", i), nld, vt[i].nld);
            chk($sformatf("v%0d_enable_cycles", i), nen, vt[i].nen);
            chk($sformatf("v%0d_asel", i), nasel, vt[i].nasel);
            chk($sformatf("v%0d_sximm8", i), {16'h0, sximm8}, {16'h0, vt[i].sx});
            if (vt[i].nwr != 0)
                chk($sformatf("v%0d_reg", i), {16'h0, regs[vt[i].rd]}, {16'h0, vt[i].val});
        end
        chk("cmp_zflag", {31'h0, zf}, 32'h0);

        // load ignored during GET_B of an ADD; ADD R2,R1,R0,LSL#1 still gives 16
        sb.push_back('{3'd2, 16'h0010});
        in = 16'hA148; load = 1'b1; s = 1'b1;
        @(negedge clk); load = 1'b0; s = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("getb_loadb", {31'h0, loadb}, 32'h1);
        in = 16'hD0AA; load = 1'b1;
        @(negedge clk); load = 1'b0;
        cyc = 4;
        while (!w && cyc < 20) begin @(negedge clk); cyc++; end
        chk("getb_w_cycle", cyc, 6);
        chk("getb_ir_kept", {16'h0, sximm8}, 32'h0048);
        chk("getb_r2", {16'h0, regs[2]}, 32'h0010);

        // async reset during EXEC of ADD R7,R1,R0 abandons it with no write
        in = 16'hA1E0; load = 1'b1; s = 1'b1;
        @(negedge clk); load = 1'b0; s = 1'b0;
        repeat (3) @(negedge clk);
        chk("exec_loadc", {31'h0, loadc}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midrst_w", {31'h0, w}, 32'h1);
        chk("midrst_loadc", {31'h0, loadc}, 32'h0);
        chk("midrst_write", {31'h0, write}, 32'h0);
        chk("midrst_ir", {16'h0, sximm8}, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        wlow = 0;
        repeat (6) begin @(negedge clk); if (!w) wlow++; end
        chk("postrst_idle", wlow, 0);

        // s held high: MOV R0,#7 repeats back-to-back with a one-cycle w gap
        repeat (3) sb.push_back('{3'd0, 16'h0007});
        in = 16'hD007; load = 1'b1; s = 1'b1;
        @(negedge clk); load = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wpat[k] = w;
            if (k == 8) s = 1'b0;
            else @(negedge clk);
        end
        chk("s_held_w_pattern", {23'h0, wpat}, {23'h0, 9'b100_100_100});
        repeat (3) @(negedge clk);
        chk("s_held_idle", {31'h0, w}, 32'h1);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Instruction register, decoder and sequencing FSM that sits directly upstream of `datapath`. It captures a 16-bit instruction and, after a start pulse, drives every `datapath` control input cycle by cycle. It executes MOV-immediate, MOV-register and the four ALU instructions, then returns to an idle state that asserts `w`. Its outputs connect one-to-one to the same-named `datapath` inputs; `sximm8` feeds `datapath_in`.

## Interface
- No parameters; widths are fixed by the `datapath` port list.
- `clk`  in  1  rising-edge clock shared with `datapath`
- `reset_n`  in  1  reset, asynchronous, active-low
- `in`  in  16  instruction word
- `load`  in  1  capture `in` into IR (accepted in WAIT only)
- `s`  in  1  start execution of the instruction held in IR (accepted in WAIT only)
- `w`  out  1  idle/ready; high exactly in WAIT
- `sximm8`  out  16  IR[7:0] sign-extended; drives `datapath_in`
- `vsel`, `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`  out  1 each  `datapath` controls
- `readnum`, `writenum`  out  3 each  register-file addresses
- `shift`, `ALUop`  out  2 each  shifter and ALU controls

## Operation
- IR fields:
  - [15:13] opcode, [12:11] op
  - [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8
- Supported instructions:
  - opcode 110, op 10: MOV Rn,#imm8
  - opcode 110, op 00: MOV Rd,Rm{,sh}
  - opcode 101, op 00: ADD Rd,Rn,Rm{,sh}
  - opcode 101, op 01: CMP Rn,Rm{,sh}
  - opcode 101, op 10: AND Rd,Rn,Rm{,sh}
  - opcode 101, op 11: MVN Rd,Rm{,sh}
- Moore FSM states: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM.
- Transitions:
  - WAIT → DECODE when `s`=1.
  - DECODE → WR_IMM for MOV-imm; → GET_B for MOV-reg and MVN; → GET_A for ADD, CMP and AND; → WAIT for any other encoding (silently ignored).
  - GET_A → GET_B.
  - GET_B → EXEC.
  - EXEC → WAIT for CMP; → WR_REG otherwise.
  - WR_REG → WAIT.
  - WR_IMM → WAIT.
- Per-state outputs (every unlisted enable is 0):
  - WAIT: `w`=1.
  - GET_A: `readnum`=Rn, `loada`=1.
  - GET_B: `readnum`=Rm, `loadb`=1.
  - EXEC:
    - `shift`=sh, `bsel`=0.
    - `asel`=1 for MOV-reg and MVN (A operand forced to 0), 0 otherwise.
    - `ALUop`=00 for MOV-reg, op otherwise.
    - `loadc`=1 except CMP; `loads`=1 only for CMP.
  - WR_REG: `vsel`=0, `writenum`=Rd, `write`=1.
  - WR_IMM: `vsel`=1, `writenum`=Rn, `write`=1.
- Outside the states above: `readnum`=Rm, `writenum`=Rd, `shift`=00, `ALUop`=00.
- `sximm8` is combinational from IR in every state.
- Input acceptance:
  - `load` and `s` outside WAIT have no effect; IR is stable throughout execution.
  - `load` and `s` together in WAIT: IR captures `in` and the FSM enters DECODE at the same edge, so the new instruction executes.
- Reset:
  - `reset_n` low at any time, mid-instruction included, forces WAIT and IR=0 immediately, without waiting for a clock edge.
  - All enables go to 0 and `w`=1; a partially executed instruction is abandoned with no write.

## Timing
- Let E be the edge that samples `s`. Cycle k is the cycle after edge E+k-1, so cycle 1 is DECODE.
- MOV-imm: DECODE in cycle 1, `write` in cycle 2; `w`=1 from cycle 3.
- MOV-reg, MVN: `loadb` in cycle 2, `loadc` in cycle 3, `write` in cycle 4; `w`=1 from cycle 5.
- ADD, AND: `loada` in cycle 2, `loadb` in cycle 3, `loadc` in cycle 4, `write` in cycle 5; `w`=1 from cycle 6.
- CMP: `loads` in cycle 4; `w`=1 from cycle 5.
- A new `s` is accepted on the first edge at which `w`=1.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode/op constants
  - state encoding (3-bit, one constant per state)
  - IR field bit positions
- One sub-module, `instr_decoder`: purely combinational. It derives Rn, Rd, Rm, sh, op, opcode and `sximm8` from IR, and produces instruction-class flags (is_movi, is_movr, is_alu, is_cmp).
- `datapath_ctrl` holds the IR, the state register and the output logic.

## Test plan
- Reset mid-EXEC of ADD → `w`=1, `loadc`=0 and `write`=0 immediately; no write occurs afterwards.
- Load 0xD007 then `s` (MOV R0,#7) → exactly one `write`, with `writenum`=0, `vsel`=1, `sximm8`=0x0007.
- Program sequence with `datapath` as the load:
  - 0xD007, 0xD102, 0xA148 (ADD R2,R1,R0,LSL#1) → R2 reads back 16.
  - 0xA900 (CMP R1,R0) → `loads` pulses once, no `write`, `w` returns after 5 cycles.
- Load 0xD5FF (MOV R5,#-1) → `sximm8`=0xFFFF, R5=0xFFFF. Then 0xB861 (MVN R3,R1, R1=2) → `asel`=1 in EXEC, R3=0xFFFD.
- Assert `load` with 0xD0AA during GET_B of an ADD → IR unchanged, ADD completes correctly. `s` held high continuously → back-to-back instructions, `w` high for exactly one cycle between them.
- Undefined opcode 0x0000 plus `s` → DECODE then WAIT, all enables stay 0.
